// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues req/ack reads to instruction memory
// and delivers each fetched word to the IR with a one-cycle IRWrite strobe.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_Fetch,
  input  logic              i_PCWrite,
  input  logic [ADDR_W-1:0] i_PCNext,
  input  logic              i_MemAck,
  input  logic [DATA_W-1:0] i_MemData,
  output logic              o_MemReq,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [DATA_W-1:0] o_Instr,
  output logic              o_IRWrite,
  output logic [ADDR_W-1:0] o_PC,
  output logic              o_Busy,
  output logic              o_Fault
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FAULT
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [ADDR_W-1:0] pend, pend_n;
  logic              pend_v, pend_v_n;
  logic [DATA_W-1:0] instr, instr_n;
  logic              irw, irw_n;
  logic [CW-1:0]     cnt, cnt_n;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] redir;
  logic              redir_v;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      pc     <= RESET_PC;
      addr   <= '0;
      pend   <= '0;
      pend_v <= 1'b0;
      instr  <= '0;
      irw    <= 1'b0;
      cnt    <= '0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      addr   <= addr_n;
      pend   <= pend_n;
      pend_v <= pend_v_n;
      instr  <= instr_n;
      irw    <= irw_n;
      cnt    <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    pc_n     = pc;
    addr_n   = addr;
    pend_n   = pend;
    pend_v_n = pend_v;
    instr_n  = instr;
    irw_n    = 1'b0;
    cnt_n    = cnt;
    tgt      = i_PCWrite ? i_PCNext : pc;
    // a redirect arriving on the completing edge is the latest write
    redir_v  = pend_v | i_PCWrite;
    redir    = i_PCWrite ? i_PCNext : pend;
    unique case (state)
      IDLE: begin
        pc_n = tgt;
        if (i_Fetch) begin
          if (tgt[1:0] == 2'b00) begin
            state_n  = REQ;
            addr_n   = tgt;
            cnt_n    = '0;
            pend_v_n = 1'b0;
          end else begin
            state_n = FAULT;
          end
        end
      end
      REQ: begin
        if (i_PCWrite) begin
          pend_n   = i_PCNext;
          pend_v_n = 1'b1;
        end
        if (i_MemAck) begin
          instr_n  = i_MemData;
          irw_n    = 1'b1;
          state_n  = IDLE;
          pc_n     = redir_v ? redir : pc + ADDR_W'(4);
          pend_v_n = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n  = FAULT;
          pend_v_n = 1'b0;
          if (redir_v) pc_n = redir;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      FAULT: begin
        if (i_PCWrite) begin
          pc_n    = i_PCNext;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign o_MemReq  = (state == REQ);
  assign o_Busy    = (state == REQ);
  assign o_Fault   = (state == FAULT);
  assign o_MemAddr = addr;
  assign o_Instr   = instr;
  assign o_IRWrite = irw;
  assign o_PC      = pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit: directed scenarios plus randomized
// traffic checked against a cycle-level behavioural model.
module tb_instr_fetch_unit;

  localparam int TMO = 16;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_Fetch = 1'b0;
  logic        i_PCWrite = 1'b0;
  logic [31:0] i_PCNext = '0;
  logic        i_MemAck = 1'b0;
  logic [31:0] i_MemData = '0;
  logic        o_MemReq;
  logic [31:0] o_MemAddr;
  logic [31:0] o_Instr;
  logic        o_IRWrite;
  logic [31:0] o_PC;
  logic        o_Busy;
  logic        o_Fault;

  int errors = 0;
  int checks = 0;

  instr_fetch_unit #(
    .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0), .TIMEOUT(TMO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_Fetch(i_Fetch),
    .i_PCWrite(i_PCWrite), .i_PCNext(i_PCNext),
    .i_MemAck(i_MemAck), .i_MemData(i_MemData),
    .o_MemReq(o_MemReq), .o_MemAddr(o_MemAddr),
    .o_Instr(o_Instr), .o_IRWrite(o_IRWrite), .o_PC(o_PC),
    .o_Busy(o_Busy), .o_Fault(o_Fault)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_Fetch = 0; i_PCWrite = 0; i_MemAck = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1;
    cyc();
    cyc();
    i_rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    i_rst = 1;
    #1;
    cyc();
    checks++; if (o_PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h want %h", o_PC, 32'h0); end
    checks++; if (o_MemReq !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", o_MemReq); end
    checks++; if (o_IRWrite !== 1'b0) begin errors++; $display("FAIL reset_irw: got %b want 0", o_IRWrite); end
    checks++; if (o_Fault !== 1'b0 || o_Busy !== 1'b0) begin errors++; $display("FAIL reset_flags: got fault=%b busy=%b want 0 0", o_Fault, o_Busy); end
    checks++; if (o_Instr !== 32'h0 || o_MemAddr !== 32'h0) begin errors++; $display("FAIL reset_data: got instr=%h addr=%h want 0 0", o_Instr, o_MemAddr); end
    i_rst = 0;
  endtask

  task automatic test_basic_fetch();
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemReq !== 1'b1 || o_Busy !== 1'b1) begin errors++; $display("FAIL basic_req: got req=%b busy=%b want 1 1", o_MemReq, o_Busy); end
    checks++; if (o_MemAddr !== 32'h0) begin errors++; $display("FAIL basic_addr: got %h want %h", o_MemAddr, 32'h0); end
    i_MemAck = 1; i_MemData = 32'h8C220004;
    cyc();
    i_MemAck = 0; i_MemData = 32'hDEADBEEF;
    checks++; if (o_IRWrite !== 1'b1) begin errors++; $display("FAIL basic_irw: got %b want 1", o_IRWrite); end
    checks++; if (o_Instr !== 32'h8C220004) begin errors++; $display("FAIL basic_instr: got %h want %h", o_Instr, 32'h8C220004); end
    checks++; if (o_PC !== 32'h4) begin errors++; $display("FAIL basic_pc: got %h want %h", o_PC, 32'h4); end
    checks++; if (o_MemReq !== 1'b0) begin errors++; $display("FAIL basic_req_drop: got %b want 0", o_MemReq); end
    cyc();
    checks++; if (o_IRWrite !== 1'b0) begin errors++; $display("FAIL basic_irw_single: got %b want 0", o_IRWrite); end
    checks++; if (o_Instr !== 32'h8C220004) begin errors++; $display("FAIL basic_instr_hold: got %h want %h", o_Instr, 32'h8C220004); end
  endtask

  task automatic test_delayed_ack();
    int pulses;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (o_MemReq !== 1'b1 || o_MemAddr !== 32'h4) begin errors++; $display("FAIL delay_req_%0d: got req=%b addr=%h want 1 %h", i, o_MemReq, o_MemAddr, 32'h4); end
      checks++; if (o_IRWrite !== 1'b0) begin errors++; $display("FAIL delay_early_irw_%0d: got %b want 0", i, o_IRWrite); end
      if (i == 4) begin i_MemAck = 1; i_MemData = 32'h12345678; end
      cyc();
    end
    i_MemAck = 0;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      if (o_IRWrite === 1'b1) pulses++;
      cyc();
    end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL delay_pulses: got %0d want 1", pulses); end
    checks++; if (o_Instr !== 32'h12345678 || o_PC !== 32'h8) begin errors++; $display("FAIL delay_result: got instr=%h pc=%h want %h %h", o_Instr, o_PC, 32'h12345678, 32'h8); end
    checks++; if (o_Fault !== 1'b0) begin errors++; $display("FAIL delay_fault: got %b want 0", o_Fault); end
  endtask

  task automatic test_timeout();
    int req_cycles;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    req_cycles = 0;
    for (int i = 0; i < TMO; i++) begin
      if (o_MemReq === 1'b1) req_cycles++;
      cyc();
    end
    checks++; if (req_cycles !== TMO) begin errors++; $display("FAIL tmo_req_cycles: got %0d want %0d", req_cycles, TMO); end
    checks++; if (o_MemReq !== 1'b0 || o_Fault !== 1'b1) begin errors++; $display("FAIL tmo_fault: got req=%b fault=%b want 0 1", o_MemReq, o_Fault); end
    checks++; if (o_PC !== 32'h8 || o_IRWrite !== 1'b0) begin errors++; $display("FAIL tmo_pc: got pc=%h irw=%b want %h 0", o_PC, o_IRWrite, 32'h8); end
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemReq !== 1'b0 || o_Fault !== 1'b1) begin errors++; $display("FAIL tmo_fetch_ignored: got req=%b fault=%b want 0 1", o_MemReq, o_Fault); end
    i_PCWrite = 1; i_PCNext = 32'h100;
    cyc();
    i_PCWrite = 0;
    checks++; if (o_Fault !== 1'b0 || o_PC !== 32'h100) begin errors++; $display("FAIL tmo_recover: got fault=%b pc=%h want 0 %h", o_Fault, o_PC, 32'h100); end
  endtask

  task automatic test_redirect_in_req();
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    i_PCWrite = 1; i_PCNext = 32'h40;
    cyc();
    i_PCWrite = 0;
    checks++; if (o_MemAddr !== 32'h100 || o_PC !== 32'h100 || o_MemReq !== 1'b1) begin errors++; $display("FAIL redir_hold: got addr=%h pc=%h req=%b want %h %h 1", o_MemAddr, o_PC, o_MemReq, 32'h100, 32'h100); end
    i_MemAck = 1; i_MemData = 32'hA5A5_0001;
    cyc();
    i_MemAck = 0;
    checks++; if (o_Instr !== 32'hA5A5_0001 || o_IRWrite !== 1'b1) begin errors++; $display("FAIL redir_instr: got %h irw=%b want %h 1", o_Instr, o_IRWrite, 32'hA5A50001); end
    checks++; if (o_PC !== 32'h40) begin errors++; $display("FAIL redir_pc: got %h want %h", o_PC, 32'h40); end
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemAddr !== 32'h40 || o_MemReq !== 1'b1) begin errors++; $display("FAIL redir_next_addr: got %h req=%b want %h 1", o_MemAddr, o_MemReq, 32'h40); end
    i_MemAck = 1;
    cyc();
    i_MemAck = 0;
    checks++; if (o_PC !== 32'h44) begin errors++; $display("FAIL redir_next_pc: got %h want %h", o_PC, 32'h44); end
  endtask

  task automatic test_misaligned_wrap();
    int reqs;
    i_PCWrite = 1; i_PCNext = 32'h6; i_Fetch = 1;
    cyc();
    idle_inputs();
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      if (o_MemReq !== 1'b0) reqs++;
      if (i < 2) cyc();
    end
    checks++; if (reqs !== 0) begin errors++; $display("FAIL mis_req: got %0d req cycles want 0", reqs); end
    checks++; if (o_Fault !== 1'b1 || o_PC !== 32'h6) begin errors++; $display("FAIL mis_fault: got fault=%b pc=%h want 1 %h", o_Fault, o_PC, 32'h6); end
    i_PCWrite = 1; i_PCNext = 32'hFFFF_FFFC;
    cyc();
    i_PCWrite = 0;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemAddr !== 32'hFFFF_FFFC || o_MemReq !== 1'b1) begin errors++; $display("FAIL wrap_addr: got %h req=%b want %h 1", o_MemAddr, o_MemReq, 32'hFFFFFFFC); end
    i_MemAck = 1; i_MemData = 32'h0000_0013;
    cyc();
    i_MemAck = 0;
    checks++; if (o_PC !== 32'h0 || o_Instr !== 32'h13) begin errors++; $display("FAIL wrap_pc: got pc=%h instr=%h want 0 13", o_PC, o_Instr); end
  endtask

  task automatic test_async_reset();
    i_PCWrite = 1; i_PCNext = 32'h200;
    cyc();
    i_PCWrite = 0;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemReq !== 1'b1) begin errors++; $display("FAIL arst_pre_req: got %b want 1", o_MemReq); end
    #2 i_rst = 1;
    #1;
    checks++; if (o_MemReq !== 1'b0 || o_Busy !== 1'b0 || o_PC !== 32'h0) begin errors++; $display("FAIL arst_req: got req=%b busy=%b pc=%h want 0 0 0", o_MemReq, o_Busy, o_PC); end
    cyc();
    i_rst = 0;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    i_MemAck = 1; i_MemData = 32'hCAFE_F00D;
    cyc();
    i_MemAck = 0;
    checks++; if (o_IRWrite !== 1'b1) begin errors++; $display("FAIL arst_irw_pre: got %b want 1", o_IRWrite); end
    #2 i_rst = 1;
    #1;
    checks++; if (o_IRWrite !== 1'b0 || o_PC !== 32'h0 || o_Instr !== 32'h0) begin errors++; $display("FAIL arst_irw: got irw=%b pc=%h instr=%h want 0 0 0", o_IRWrite, o_PC, o_Instr); end
    cyc();
    i_rst = 0;
    i_Fetch = 1;
    cyc();
    i_Fetch = 0;
    checks++; if (o_MemAddr !== 32'h0 || o_MemReq !== 1'b1) begin errors++; $display("FAIL arst_refetch_addr: got %h req=%b want 0 1", o_MemAddr, o_MemReq); end
    i_MemAck = 1; i_MemData = 32'h0BAD_CAFE;
    cyc();
    i_MemAck = 0;
    checks++; if (o_Instr !== 32'h0BAD_CAFE || o_PC !== 32'h4) begin errors++; $display("FAIL arst_refetch: got instr=%h pc=%h want %h 4", o_Instr, o_PC, 32'h0BADCAFE); end
  endtask

  // Behavioural model: a fetch in flight, a list of redirects requested while
  // it is outstanding, and a sticky fault condition.
  logic [31:0] m_pc, m_addr, m_instr;
  logic        m_irw;
  bit          m_busy, m_fault;
  int          m_waited;
  logic [31:0] m_redirects[$];

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0;
    m_irw = 0; m_busy = 0; m_fault = 0; m_waited = 0;
    m_redirects.delete();
  endtask

  task automatic model_edge();
    logic [31:0] target;
    m_irw = 0;
    if (m_fault) begin
      if (i_PCWrite) begin m_pc = i_PCNext; m_fault = 0; end
    end else if (m_busy) begin
      if (i_PCWrite) m_redirects.push_back(i_PCNext);
      if (i_MemAck) begin
        m_instr = i_MemData;
        m_irw = 1;
        m_busy = 0;
        m_pc = (m_redirects.size() > 0) ? m_redirects[$] : m_pc + 32'd4;
        m_redirects.delete();
      end else begin
        m_waited++;
        if (m_waited == TMO) begin
          m_busy = 0;
          m_fault = 1;
          if (m_redirects.size() > 0) m_pc = m_redirects[$];
          m_redirects.delete();
        end
      end
    end else begin
      target = i_PCWrite ? i_PCNext : m_pc;
      m_pc = target;
      if (i_Fetch) begin
        if (target % 4 == 0) begin
          m_busy = 1; m_addr = target; m_waited = 0;
        end else begin
          m_fault = 1;
        end
      end
    end
  endtask

  task automatic test_random();
    int prev_irw;
    do_reset();
    model_reset();
    prev_irw = 0;
    for (int n = 0; n < 3000; n++) begin
      i_Fetch   = ($urandom_range(0, 99) < 50);
      i_PCWrite = ($urandom_range(0, 99) < 15);
      i_PCNext  = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if ($urandom_range(0, 19) == 0) i_PCNext = 32'hFFFF_FFFC;
      i_MemAck  = ($urandom_range(0, 99) < 40);
      i_MemData = $urandom;
      model_edge();
      cyc();
      checks++; if (o_PC !== m_pc) begin errors++; $display("FAIL rnd_pc@%0d: got %h want %h", n, o_PC, m_pc); end
      checks++; if (o_MemReq !== m_busy || o_Busy !== m_busy) begin errors++; $display("FAIL rnd_req@%0d: got req=%b busy=%b want %b", n, o_MemReq, o_Busy, m_busy); end
      checks++; if (o_Fault !== m_fault) begin errors++; $display("FAIL rnd_fault@%0d: got %b want %b", n, o_Fault, m_fault); end
      checks++; if (o_IRWrite !== m_irw || o_Instr !== m_instr) begin errors++; $display("FAIL rnd_ir@%0d: got irw=%b instr=%h want %b %h", n, o_IRWrite, o_Instr, m_irw, m_instr); end
      if (m_busy) begin
        checks++; if (o_MemAddr !== m_addr) begin errors++; $display("FAIL rnd_addr@%0d: got %h want %h", n, o_MemAddr, m_addr); end
      end
      if (prev_irw == 1) begin
        checks++; if (o_IRWrite !== 1'b0) begin errors++; $display("FAIL rnd_irw_double@%0d: got %b want 0", n, o_IRWrite); end
      end
      prev_irw = (o_IRWrite === 1'b1) ? 1 : 0;
    end
    idle_inputs();
  endtask

  initial begin
    cyc();
    test_reset();
    test_basic_fetch();
    test_delayed_ack();
    test_timeout();
    test_redirect_in_req();
    test_misaligned_wrap();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
